sw_led_modes: RTL and testbench

//   Parametrised successor to the switch-to-LED passthrough. It samples WIDTH board

---
 rtl/sw_led_modes.sv | 132 +++++++++++++
 tb/tb_sw_led_modes.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sw_led_modes.sv
// sw_led_modes: synchronised, debounced board switches driving registered LEDs
// in one of four modes (pass, invert, chase, counter). MODE is synchronised
// but not debounced. Every output bit comes straight from a flop.
module sw_led_modes #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 25_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] SW,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] LED
);

  // A debounce counter never needs to hold more than DEBOUNCE_CYCLES-1.
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TKW = $clog2(TICK_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_CYCLES - 1);
  localparam logic [WIDTH-1:0] CHASE_INIT = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_INV   = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_CNT   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sw_s1_q, sw_s1_d;
  logic [WIDTH-1:0] sw_s2_q, sw_s2_d;
  logic [WIDTH-1:0] sw_stable_q, sw_stable_d;
  logic [DBW-1:0]   db_cnt_q [WIDTH];
  logic [DBW-1:0]   db_cnt_d [WIDTH];
  logic [1:0]       mode_s1_q, mode_s1_d;
  mode_e            mode_q, mode_d;
  logic [TKW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0] chase_q, chase_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             mode_chg;
  logic             tick;

  // Two-flop synchronisers for the raw switch and mode inputs.
  always_comb begin
    sw_s1_d   = SW;
    sw_s2_d   = sw_s1_q;
    mode_s1_d = MODE;
    mode_d    = mode_e'(mode_s1_q);
  end

  // Per-bit debounce: a bit is accepted only after differing for DEBOUNCE_CYCLES edges.
  always_comb begin
    sw_stable_d = sw_stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = '0;
      if (sw_s2_q[i] != sw_stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          sw_stable_d[i] = sw_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  // Step timer and mode-entry handling; a mode change overrides a coincident tick.
  always_comb begin
    mode_chg   = (mode_e'(mode_s1_q) != mode_q);
    tick       = (tick_cnt_q == TK_LAST);
    tick_cnt_d = (mode_chg || tick) ? '0 : tick_cnt_q + TKW'(1);
    chase_d    = chase_q;
    count_d    = count_q;
    if (mode_chg) begin
      chase_d = CHASE_INIT;
      count_d = sw_stable_q;
    end else if (tick) begin
      if (mode_q == MODE_CHASE) begin
        chase_d = {chase_q[WIDTH-2:0], chase_q[WIDTH-1]};
      end
      if (mode_q == MODE_CNT) begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // LED source selected by the registered mode.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_PASS:  led_d = sw_stable_q;
      MODE_INV:   led_d = ~sw_stable_q;
      MODE_CHASE: led_d = chase_q;
      MODE_CNT:   led_d = count_q;
      default:    led_d = '0;
    endcase
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sw_stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i] <= '0;
      end
      mode_s1_q   <= 2'b00;
      mode_q      <= MODE_PASS;
      tick_cnt_q  <= '0;
      chase_q     <= CHASE_INIT;
      count_q     <= '0;
      led_q       <= '0;
    end else begin
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      sw_stable_q <= sw_stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      mode_s1_q   <= mode_s1_d;
      mode_q      <= mode_d;
      tick_cnt_q  <= tick_cnt_d;
      chase_q     <= chase_d;
      count_q     <= count_d;
      led_q       <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_sw_led_modes.sv
// Bench for sw_led_modes: directed scenarios with fixed expectations, then
// randomized switch/mode/reset activity, every edge compared to a reference model.
module tb_sw_led_modes;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int TC = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [1:0]   mode;
  logic [W-1:0] led;

  int n_asrt = 0;
  int n_fail = 0;

  sw_led_modes #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB),
    .TICK_CYCLES(TC)
  ) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .SW(sw),
    .MODE(mode),
    .LED(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: input delay lines, debounced word, sampled-history
  // window, chase position as an index, counter value, and the edge at which
  // the step timer last restarted.
  int           e      = 0;
  int           e0     = 0;
  logic [W-1:0] m_s1   = '0;
  logic [W-1:0] m_s2   = '0;
  logic [W-1:0] m_stab = '0;
  logic [W-1:0] m_led  = '0;
  logic [W-1:0] m_cnt  = '0;
  logic [1:0]   m_ms1  = '0;
  logic [1:0]   m_mode = '0;
  int           m_pos  = 0;
  logic [W-1:0] hist[$];

  task automatic model_edge(input logic rstn, input logic [W-1:0] s, input logic [1:0] md);
    logic [W-1:0] nstab;
    logic [W-1:0] nled;
    logic         chg;
    logic         tk;
    logic         all_diff;
    e++;
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_led = '0; m_cnt = '0;
      m_ms1 = '0; m_mode = '0; m_pos = 0; e0 = e;
      hist.delete();
    end else begin
      // A bit flips once its last DB synchronised samples all disagree with it.
      hist.push_back(m_s2);
      if (hist.size() > DB) void'(hist.pop_front());
      nstab = m_stab;
      if (hist.size() == DB) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++) if (hist[j][b] == m_stab[b]) all_diff = 1'b0;
          if (all_diff) nstab[b] = ~m_stab[b];
        end
      end
      case (m_mode)
        2'b00:   nled = m_stab;
        2'b01:   nled = ~m_stab;
        2'b10:   nled = 8'h01 << m_pos;
        default: nled = m_cnt;
      endcase
      tk  = (((e - 1 - e0) % TC) == TC - 1);
      chg = (m_ms1 != m_mode);
      if (chg) begin
        e0 = e; m_pos = 0; m_cnt = m_stab;
      end else if (tk) begin
        if (m_mode == 2'b10) m_pos = (m_pos + 1) % W;
        if (m_mode == 2'b11) m_cnt = m_cnt + 8'd1;
      end
      m_mode = m_ms1; m_ms1 = md;
      m_s2 = m_s1; m_s1 = s;
      m_stab = nstab; m_led = nled;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
    n_asrt++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock edge: advance the model on the sampled inputs, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(rst_n, sw, mode);
    #1;
    check("model", led, m_led);
  endtask

  initial begin
    int hold;
    logic [W-1:0] want;
    rst_n = 1'b0; sw = 8'hFF; mode = 2'b01;

    // Reset held for 3 edges with all switches on and invert selected.
    for (int i = 0; i < 3; i++) begin step(); check("reset_led", led, 8'h00); end
    rst_n = 1'b1; mode = 2'b00;
    for (int i = 0; i < 6; i++) begin step(); check("post_reset_hold", led, 8'h00); end
    step(); check("post_reset_latency", led, 8'hFF);

    // Pass mode latency.
    sw = 8'h00;
    repeat (10) step();
    check("pass_idle", led, 8'h00);
    sw = 8'hA5;
    for (int i = 0; i < 6; i++) step();
    check("pass_edge6", led, 8'h00);
    step(); check("pass_edge7", led, 8'hA5);

    // Glitch rejection, then acceptance.
    sw = 8'h5A; repeat (3) step();
    sw = 8'hA5;
    for (int i = 0; i < 10; i++) begin step(); check("glitch_reject", led, 8'hA5); end
    sw = 8'h5A; repeat (8) step();
    check("glitch_accept", led, 8'h5A);

    // Invert mode entry timing.
    sw = 8'h0F; repeat (10) step();
    check("inv_before", led, 8'h0F);
    mode = 2'b01;
    step(); check("inv_edge1", led, 8'h0F);
    step(); check("inv_edge2", led, 8'h0F);
    step(); check("inv_edge3", led, 8'hF0);

    // Chase through a full wrap.
    mode = 2'b10;
    repeat (3) step();
    check("chase_start", led, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      repeat (TC) step();
      want = 8'h01 << (k % 8);
      check("chase_step", led, want);
    end

    // Counter wrap from the loaded switch value, then reset mid-count.
    sw = 8'hFE; repeat (8) step();
    mode = 2'b11;
    repeat (3) step();
    check("cnt_load", led, 8'hFE);
    repeat (TC) step(); check("cnt_tick1", led, 8'hFF);
    sw = 8'h33;
    repeat (TC) step(); check("cnt_wrap", led, 8'h00);
    repeat (3) step();
    rst_n = 1'b0;
    step(); check("cnt_reset", led, 8'h00);
    rst_n = 1'b1;

    // Randomized switches, modes and occasional resets against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        sw   = W'($urandom);
        hold = $urandom_range(1, 2 * DB + 2);
      end
      hold--;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
